nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock through a single combinational 4-bit slice. The carry is held in a register between nibbles, and the result is assembled in place. It sits between the operand source and the result consumer, with a valid/ready handshake on each side. This trades latency for area against a full-width ripple or carry-lookahead adder.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived number of nibbles; not overridable.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result is valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement signed overflow.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **Reset:** rst_n low forces the following immediately, regardless of clk:
  - state = IDLE, nibble counter k = 0;
  - operand, sum, carry and ovf registers cleared;
  - resulting outputs: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- **IDLE:**
  - in_ready=1.
  - On in_valid && in_ready: latch a, b into a_r, b_r; carry_r ← cin; k ← 0; go to RUN.
- **RUN:** in_ready=0, out_valid=0. Each cycle:
  - The slice computes a_r[4k+3:4k] + b_r[4k+3:4k] + carry_r.
  - The 4-bit result is written to sum_r[4k+3:4k], and carry_r is updated with the slice carry out.
  - If k == NIB-1: compute ovf_r = (a_r[W-1] ^ s) & (b_r[W-1] ^ s), where s is the new sum MSB; go to DONE. Otherwise k ← k+1.
- **DONE:**
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready: go to IDLE and deassert out_valid.
  - sum, cout and ovf keep their last values afterwards; they are defined only while out_valid=1.
- There is no operand overlap. in_valid is ignored outside IDLE, so operands presented in RUN or DONE are not captured.
- sum is driven from sum_r. Intermediate nibble values may be visible during RUN; consumers must sample only on out_valid.
- Arithmetic:
  - unsigned: {cout, sum} = a + b + cin exactly;
  - signed: ovf=1 exactly when a and b have the same sign and sum has the opposite sign;
  - cin participates in ovf.
- **Reset mid-operation:** the operation is abandoned with no result. The block is ready for new operands in the first cycle after rst_n releases.

## Timing
- Acceptance edge is E0. RUN updates occur on edges E1..E_NIB.
- out_valid rises after edge E_NIB: NIB cycles of latency, 4 for WIDTH=16.
- If out_ready is high in the first DONE cycle, the handshake completes on edge E_NIB+1 and in_ready is high from then on.
- Minimum initiation interval is NIB+2 cycles: accept, NIB RUN cycles, one DONE cycle, then the next accept.
- in_ready and out_valid are decoded directly from the state register. No combinational path exists from in_valid or out_ready to any output.
- The carry path per cycle is one 4-bit slice, independent of WIDTH.

## Structure
- Shared package/include file adder_pkg holds:
  - the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the constant NIBBLE_W=4.
- One sub-module, nibble_add_slice: a combinational 4-bit add with carry in and carry out (s[3:0], co, x[3:0], y[3:0], ci). It is instantiated once.
- The top level holds the FSM, the counter k (width clog2(NIB)), the operand, sum and carry registers, and nibble select/write logic indexed by k.

## Test plan
All scenarios use WIDTH=16.
- **Basic add:** a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- **Full carry ripple:** a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. This proves carry_r propagates across all nibble boundaries.
- **Signed overflow:** a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- **cin path:** a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
- **Backpressure:**
  - Hold out_ready=0 for 6 cycles in DONE → out_valid, sum and cout stable, in_ready=0.
  - A new in_valid with a=0x1111 is ignored during DONE.
  - After out_ready pulses, the next accepted operation gives the correct result.
- **Reset mid-RUN:**
  - Assert rst_n=0 asynchronously at k=2 → out_valid=0, sum=0, cout=0, ovf=0 and in_ready=1 immediately.
  - After release, a=0x00FF, b=0x0001 → sum=0x0100, cout=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encodings and slice width.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit adder slice with carry in and carry out.
module nibble_add_slice
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int KW  = $clog2(NIB);
    localparam logic [KW-1:0] LAST_K = KW'(NIB - 1);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] sliceX, sliceY, sliceS;
    logic                sliceCo;

    // Nibble k of each operand feeds the single shared slice.
    assign sliceX = a_q[{k_q, 2'b00} +: NIBBLE_W];
    assign sliceY = b_q[{k_q, 2'b00} +: NIBBLE_W];

    nibble_add_slice u_slice (
        .x  (sliceX),
        .y  (sliceY),
        .ci (carry_q),
        .s  (sliceS),
        .co (sliceCo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{k_q, 2'b00} +: NIBBLE_W] = sliceS;
                carry_d = sliceCo;
                // The last slice's MSB is the final sum sign used for overflow.
                if (k_q == LAST_K) begin
                    ovf_d   = (a_q[WIDTH-1] ^ sliceS[NIBBLE_W-1]) &
                              (b_q[WIDTH-1] ^ sliceS[NIBBLE_W-1]);
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): table-driven vectors
// through a scoreboard queue, plus backpressure and mid-run reset sequences.
module tb_nibble_serial_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] expSum;
        logic        expCout;
        logic        expOvf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int   checks;
    int   failures;
    vec_t vecs [9];
    vec_t scoreboard [$];

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        checkValue("in_ready before accept", 32'(in_ready), 32'd1);
    endtask

    // Drive one operand set, record the expected result, and return just after the accept edge.
    task automatic applyStimulus(input vec_t v);
        waitReady();
        scoreboard.push_back(v);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        cin      = 1'b0;
    endtask

    // Wait for the result, check latency and values, then complete the output handshake.
    task automatic checkOutput(input int holdCycles);
        int    lat = 0;
        vec_t  exp;
        logic [15:0] heldSum;
        logic        heldCout;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checkValue("latency", 32'(lat), 32'd4);
        checkValue("out_valid", 32'(out_valid), 32'd1);
        if (scoreboard.size() == 0) begin
            checkValue("scoreboard empty", 32'd1, 32'd0);
            exp = '{default: '0};
        end else begin
            exp = scoreboard.pop_front();
        end
        checkValue("sum", 32'(sum), 32'(exp.expSum));
        checkValue("cout", 32'(cout), 32'(exp.expCout));
        checkValue("ovf", 32'(ovf), 32'(exp.expOvf));
        heldSum  = sum;
        heldCout = cout;
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111;
            b        = 16'h1111;
            step();
            checkValue("hold out_valid", 32'(out_valid), 32'd1);
            checkValue("hold in_ready", 32'(in_ready), 32'd0);
            checkValue("hold sum", 32'(sum), 32'(heldSum));
            checkValue("hold cout", 32'(cout), 32'(heldCout));
        end
        in_valid  = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkValue("post-accept out_valid", 32'(out_valid), 32'd0);
        checkValue("post-accept in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        cin       = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

        #12;
        checkValue("reset out_valid", 32'(out_valid), 32'd0);
        checkValue("reset in_ready", 32'(in_ready), 32'd1);
        checkValue("reset sum", 32'(sum), 32'd0);
        checkValue("reset cout", 32'(cout), 32'd0);
        checkValue("reset ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(0);
        end

        // Backpressure: result held for 6 cycles while a stray operand is offered.
        applyStimulus(vecs[0]);
        checkOutput(6);
        step();
        step();
        checkValue("stray operand not captured", 32'(out_valid), 32'd0);
        checkValue("idle after backpressure", 32'(in_ready), 32'd1);
        applyStimulus('{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0});
        checkOutput(0);

        // Reset mid-RUN at k=2: partial sum and carry are nonzero before reset.
        waitReady();
        a        = 16'hFFFF;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checkValue("mid-run sum nonzero", 32'(sum != 16'h0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async reset out_valid", 32'(out_valid), 32'd0);
        checkValue("async reset sum", 32'(sum), 32'd0);
        checkValue("async reset cout", 32'(cout), 32'd0);
        checkValue("async reset ovf", 32'(ovf), 32'd0);
        checkValue("async reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkValue("ready after reset release", 32'(in_ready), 32'd1);
        applyStimulus('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0});
        checkOutput(0);

        checkValue("scoreboard drained", 32'(scoreboard.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
